// File: rtl/dom_and_pipe.sv
// Pipelined domain-oriented masked AND: z = x & y over SHARES shares.
// Stage 1 registers every cross-domain product as a glitch barrier; stage 2 compresses per domain.

module dom_and_domain #(
  parameter int SHARES = 2,
  parameter int WIDTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ld1,
  input  logic                           ld2,
  input  logic [WIDTH-1:0]               xi,
  input  logic [SHARES-1:0][WIDTH-1:0]   y,
  input  logic [SHARES-1:0][WIDTH-1:0]   m,
  output logic [WIDTH-1:0]               zi
);
  logic [SHARES-1:0][WIDTH-1:0] d_n, d_q;
  logic [SHARES:0][WIDTH-1:0]   acc;

  assign acc[0] = '0;

  // m carries r_p for cross-domain terms and zero on the diagonal
  for (genvar j = 0; j < SHARES; j++) begin : g_term
    assign d_n[j]   = (xi & y[j]) ^ m[j];
    assign acc[j+1] = acc[j] ^ d_q[j];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   d_q <= '0;
    else if (ld1) d_q <= d_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   zi <= '0;
    else if (ld2) zi <= acc[SHARES];
  end
endmodule

module dom_and_pipe #(
  parameter int SHARES = 2,
  parameter int WIDTH  = 4,
  parameter int NRAND  = WIDTH * SHARES * (SHARES - 1) / 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SHARES*WIDTH-1:0]   x_sh,
  input  logic [SHARES*WIDTH-1:0]   y_sh,
  input  logic [NRAND-1:0]          r,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [SHARES*WIDTH-1:0]   z_sh,
  output logic                      out_valid,
  input  logic                      out_ready
);
  localparam int STAGES = 2;
  localparam int NPAIR  = SHARES * (SHARES - 1) / 2;

  // lexicographic index of pair (a,b), a<b
  function automatic int pidx(input int a, input int b);
    return a * SHARES - a * (a + 1) / 2 + b - a - 1;
  endfunction

  logic [SHARES-1:0][WIDTH-1:0]              xs, ys, zs;
  logic [NPAIR-1:0][WIDTH-1:0]               rs;
  logic [SHARES-1:0][SHARES-1:0][WIDTH-1:0]  mask;
  logic [STAGES:1]                           vld_q;
  logic [STAGES:0]                           vld_pipe;
  logic                                      en, ld1, ld2;

  assign xs   = x_sh;
  assign ys   = y_sh;
  assign rs   = r;
  assign z_sh = zs;

  assign vld_pipe  = {vld_q, in_valid};
  assign out_valid = vld_pipe[STAGES];
  assign en        = ~vld_pipe[STAGES] | out_ready;
  assign in_ready  = en;
  assign ld1       = en & vld_pipe[0];
  assign ld2       = en & vld_pipe[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  vld_q <= '0;
    else if (en) vld_q <= vld_pipe[STAGES-1:0];
  end

  // d_ij and d_ji share the same r_p
  for (genvar i = 0; i < SHARES; i++) begin : g_mrow
    for (genvar j = 0; j < SHARES; j++) begin : g_mcol
      if (i == j) begin : g_diag
        assign mask[i][j] = '0;
      end else begin : g_cross
        localparam int P = (i < j) ? pidx(i, j) : pidx(j, i);
        assign mask[i][j] = rs[P];
      end
    end
  end

  for (genvar i = 0; i < SHARES; i++) begin : g_dom
    dom_and_domain #(.SHARES(SHARES), .WIDTH(WIDTH)) u_dom (
      .clk   (clk),
      .rst_n (rst_n),
      .ld1   (ld1),
      .ld2   (ld2),
      .xi    (xs[i]),
      .y     (ys),
      .m     (mask[i]),
      .zi    (zs[i])
    );
  end
endmodule

// File: tb/tb_dom_and_pipe.sv
// Scoreboard bench for dom_and_pipe: SHARES=2 directed/stream/stall/reset and SHARES=3 random with r-refresh.

module tb_dom_and_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]  x_sh2, y_sh2, z_sh2;
  logic [3:0]  r2;
  logic        in_valid2, in_ready2, out_valid2, out_ready2;

  logic [11:0] x_sh3, y_sh3, z_sh3, r3;
  logic        in_valid3, in_ready3, out_valid3, out_ready3;
  bit          bp3_en = 1'b0;

  dom_and_pipe #(.SHARES(2), .WIDTH(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .x_sh(x_sh2), .y_sh(y_sh2), .r(r2),
    .in_valid(in_valid2), .in_ready(in_ready2), .z_sh(z_sh2),
    .out_valid(out_valid2), .out_ready(out_ready2)
  );

  dom_and_pipe #(.SHARES(3), .WIDTH(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .x_sh(x_sh3), .y_sh(y_sh3), .r(r3),
    .in_valid(in_valid3), .in_ready(in_ready3), .z_sh(z_sh3),
    .out_valid(out_valid3), .out_ready(out_ready3)
  );

  typedef struct {
    logic [3:0] val;
    bit         exact;
    logic [7:0] sh;
  } exp2_t;

  exp2_t       q2[$];
  logic [3:0]  q3[$];
  logic [11:0] got3[$];
  logic [11:0] expd[$];

  function automatic logic [3:0] xr(input logic [11:0] v, input int n);
    logic [3:0] a = '0;
    for (int i = 0; i < n; i++) a ^= v[i*4 +: 4];
    return a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // scoreboard monitors: sample on the falling edge, transfer happens at the next rising edge
  always @(negedge clk) begin
    exp2_t e;
    if (rst_n && out_valid2 && out_ready2) begin
      if (q2.size() == 0) begin
        checks++; failures++;
        $display("FAIL mon2_unexpected actual=%0h required=no_output", z_sh2);
      end else begin
        e = q2.pop_front();
        chk("mon2_xor", {28'h0, xr({4'h0, z_sh2}, 2)}, {28'h0, e.val});
        if (e.exact) chk("mon2_shares", {24'h0, z_sh2}, {24'h0, e.sh});
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] e3;
    if (rst_n && out_valid3 && out_ready3) begin
      if (q3.size() == 0) begin
        checks++; failures++;
        $display("FAIL mon3_unexpected actual=%0h required=no_output", z_sh3);
      end else begin
        e3 = q3.pop_front();
        chk("mon3_xor", {28'h0, xr(z_sh3, 3)}, {28'h0, e3});
        got3.push_back(z_sh3);
      end
    end
  end

  initial begin
    logic [31:0] t;
    forever begin
      @(posedge clk); #1;
      if (bp3_en) begin t = $urandom; out_ready3 = t[0]; end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic send2(input logic [7:0] x, input logic [7:0] y, input logic [3:0] r,
                       input bit ex, input logic [7:0] sh, output int waited);
    exp2_t e;
    x_sh2 = x; y_sh2 = y; r2 = r; in_valid2 = 1'b1; waited = 0;
    @(negedge clk);
    while (!in_ready2 && waited < 200) begin waited++; @(negedge clk); end
    if (!in_ready2) begin
      checks++; failures++;
      $display("FAIL send2_timeout actual=in_ready0 required=in_ready1");
    end else begin
      e.val = (x[3:0] ^ x[7:4]) & (y[3:0] ^ y[7:4]);
      e.exact = ex; e.sh = sh;
      q2.push_back(e);
    end
    @(posedge clk); #1 in_valid2 = 1'b0;
  endtask

  task automatic send3(input logic [11:0] x, input logic [11:0] y, input logic [11:0] r);
    int n = 0;
    x_sh3 = x; y_sh3 = y; r3 = r; in_valid3 = 1'b1;
    @(negedge clk);
    while (!in_ready3 && n < 200) begin n++; @(negedge clk); end
    if (!in_ready3) begin
      checks++; failures++;
      $display("FAIL send3_timeout actual=in_ready0 required=in_ready1");
    end else q3.push_back(xr(x, 3) & xr(y, 3));
    @(posedge clk); #1 in_valid3 = 1'b0;
  endtask

  // expects an empty pipe and out_ready2=1; checks latency 2 from accept
  task automatic lat2(input logic [7:0] x, input logic [7:0] y, input logic [3:0] r, input logic [7:0] sh);
    exp2_t e;
    x_sh2 = x; y_sh2 = y; r2 = r; in_valid2 = 1'b1;
    @(negedge clk);
    chk("lat_in_ready", {31'h0, in_ready2}, 32'h1);
    e.val = (x[3:0] ^ x[7:4]) & (y[3:0] ^ y[7:4]); e.exact = 1'b1; e.sh = sh;
    q2.push_back(e);
    @(posedge clk); #1 in_valid2 = 1'b0;
    @(negedge clk);
    chk("lat_stage1_only", {31'h0, out_valid2}, 32'h0);
    @(negedge clk);
    chk("lat_out_valid", {31'h0, out_valid2}, 32'h1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] t;
    logic [7:0]  ax, ay, bx, by, cx, cy;
    logic [11:0] x3, y3, rr3, d, sd;
    int          w, n, p;

    x_sh2 = '0; y_sh2 = '0; r2 = '0; in_valid2 = 1'b0; out_ready2 = 1'b1;
    x_sh3 = '0; y_sh3 = '0; r3 = '0; in_valid3 = 1'b0; out_ready3 = 1'b1;
    x3 = '0; y3 = '0; rr3 = '0;

    #12;
    chk("rst_out_valid2", {31'h0, out_valid2}, 32'h0);
    chk("rst_z_sh2", {24'h0, z_sh2}, 32'h0);
    chk("rst_in_ready2", {31'h0, in_ready2}, 32'h1);
    chk("rst_out_valid3", {31'h0, out_valid3}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // x=0xA as 3/9, y=0xC as 5/9, r=6 -> shares 6/E
    lat2(8'h93, 8'h95, 4'h6, 8'hE6);

    for (int k = 0; k < 16; k++) begin
      t = $urandom;
      send2(t[7:0], t[15:8], t[19:16], 1'b0, 8'h00, w);
      chk("stream_in_ready_wait", w, 0);
    end
    repeat (3) @(posedge clk); #1;
    chk("stream_drained", q2.size(), 0);

    // stall with both stages full
    t = $urandom; ax = t[7:0]; ay = t[15:8]; bx = t[23:16]; by = t[31:24];
    t = $urandom; cx = t[7:0]; cy = t[15:8];
    out_ready2 = 1'b0;
    send2(ax, ay, t[19:16], 1'b0, 8'h00, w);
    send2(bx, by, t[23:20], 1'b0, 8'h00, w);
    x_sh2 = cx; y_sh2 = cy; in_valid2 = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", {31'h0, in_ready2}, 32'h0);
      chk("stall_out_valid", {31'h0, out_valid2}, 32'h1);
      chk("stall_z_hold", {28'h0, xr({4'h0, z_sh2}, 2)}, {28'h0, (ax[3:0] ^ ax[7:4]) & (ay[3:0] ^ ay[7:4])});
      @(posedge clk); #1;
    end
    out_ready2 = 1'b1;
    send2(cx, cy, t[27:24], 1'b0, 8'h00, w);
    chk("stall_release_accept", w, 0);
    repeat (3) @(posedge clk); #1;
    chk("stall_drained", q2.size(), 0);

    // asynchronous reset between edges drops in-flight work
    for (int k = 0; k < 3; k++) begin
      t = $urandom;
      send2(t[7:0], t[15:8], t[19:16], 1'b0, 8'h00, w);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'h0, out_valid2}, 32'h0);
    chk("midrst_z_sh", {24'h0, z_sh2}, 32'h0);
    chk("midrst_in_ready", {31'h0, in_ready2}, 32'h1);
    q2.delete();
    @(negedge clk) rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_stale", {31'h0, out_valid2}, 32'h0);
    end
    @(posedge clk); #1;
    lat2(8'h93, 8'h95, 4'h6, 8'hE6);
    repeat (2) @(posedge clk); #1;
    chk("post_rst_drained", q2.size(), 0);

    // SHARES=3: odd transactions repeat x,y with r changed by a known delta
    bp3_en = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (k % 2 == 0) begin
        t = $urandom; x3 = t[11:0]; y3 = t[23:12];
        t = $urandom; rr3 = t[11:0];
      end else begin
        d = 12'($urandom_range(1, 4095));
        rr3 = rr3 ^ d;
        sd = '0; p = 0;
        for (int a = 0; a < 3; a++)
          for (int b = a + 1; b < 3; b++) begin
            sd[a*4 +: 4] = sd[a*4 +: 4] ^ d[p*4 +: 4];
            sd[b*4 +: 4] = sd[b*4 +: 4] ^ d[p*4 +: 4];
            p++;
          end
        expd.push_back(sd);
      end
      send3(x3, y3, rr3);
    end
    n = 0;
    while (q3.size() != 0 && n < 1000) begin @(posedge clk); n++; end
    bp3_en = 1'b0;
    chk("s3_drained", q3.size(), 0);
    #1 out_ready3 = 1'b1;
    chk("s3_output_count", got3.size(), 100);
    if (got3.size() == 100) begin
      for (int k = 0; k < 50; k++)
        chk("s3_rdelta_shares", {20'h0, got3[2*k] ^ got3[2*k+1]}, {20'h0, expd[k]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dom_and_pipe.md
# dom_and_pipe

Parametrised, pipelined masked AND gadget in domain-oriented (DOM) style for the masked PRINCE datapath and its successors. It computes one WIDTH-bit bitwise AND of two SHARES-share inputs, x and y, and produces a SHARES-share output. Every cross-domain product is refreshed with fresh randomness and registered as a glitch barrier before compression. A valid/ready handshake with full back-pressure lets it sit between S-box layers or feed other gadgets directly.

## Interface
- SHARES, default 2, number of shares per variable (≥2; protection order SHARES−1)
- WIDTH, default 4, bits per share (one S-box nibble by default)
- NRAND, derived = WIDTH·SHARES·(SHARES−1)/2, fresh random bits per transaction
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- x_sh  input  SHARES·WIDTH  shares of x, share i at bits [i·WIDTH +: WIDTH]
- y_sh  input  SHARES·WIDTH  shares of y, same layout
- r  input  NRAND  fresh randomness, pair p at bits [p·WIDTH +: WIDTH]
- in_valid  input  1  x_sh, y_sh and r valid this cycle
- in_ready  output  1  block accepts a transaction this cycle
- z_sh  output  SHARES·WIDTH  shares of z = x & y, same layout
- out_valid  output  1  z_sh valid
- out_ready  input  1  downstream accepts z_sh

## Operation
- Pair index p enumerates pairs (i,j), i<j, lexicographically: (0,1)=0, (0,2)=1, …, (1,2)=SHARES−1, …
- Inner-domain term for each i: d_ii = x_i & y_i.
- Cross-domain term for each i≠j: d_ij = (x_i & y_j) ^ r_p, where p is the index of pair (min(i,j), max(i,j)). Both d_ij and d_ji use the same r_p.
- Stage 1, the glitch barrier: all SHARES² terms d_ij are registered individually. No XOR across domains happens before this register.
- Stage 2, compression: z_i = XOR over j of reg(d_ij), registered into z_sh. Result: XOR of all z_i = (XOR x_i) & (XOR y_i).
- Global advance enable: en = ~out_valid | out_ready, where out_valid means stage 2 is valid. Both stages advance only when en=1.
- in_ready = en.
- Transfer: a transaction is accepted when in_valid & in_ready. Output is consumed when out_valid & out_ready.
- Stage-1 data registers load only when en & in_valid and hold otherwise, so no toggling on idle inputs. The stage-1 valid bit loads in_valid when en.
- Stage-2 data loads when en & v1. out_valid loads v1 when en.
- No combinational path from x_sh, y_sh or r to z_sh. in_ready depends only on out_valid and out_ready.
- r must be fresh and uniform per accepted transaction. The block does not check this; the testbench supplies it.

## Timing
- Reset (rst_n=0, asynchronous): all d_ij registers, z_sh, v1 and out_valid are 0, so in_ready=1.
- Deassertion of reset is synchronised externally. The first accept can happen at the first edge after release.
- Latency: accept at edge k gives out_valid=1 and z_sh valid after edge k+1.
- Throughput: one transaction per cycle while out_ready=1.
- Stall (out_valid=1, out_ready=0): in_ready=0, both stages hold, z_sh is stable. The stage-1 transaction is kept and not overwritten.
- Release of stall: at the edge with out_ready=1 the output is consumed, stage 1 moves to stage 2, and a new input is accepted in the same edge.
- Bubbles: in_valid=0 with en=1 clears v1. Stage-1 data registers keep their old contents.
- Reset mid-operation: all in-flight transactions are dropped, with no partial output. out_valid=0 immediately, independent of clk.
- Edge widths: with SHARES=2, NRAND=WIDTH. Behaviour is identical for any WIDTH≥1.

## Test plan
- SHARES=2, WIDTH=4, x shares 0x3/0x9 (x=0xA), y shares 0x5/0x9 (y=0xC), r=0x6, out_ready=1 -> two cycles later out_valid=1, z_sh shares 0x6/0xE, XOR 0x8.
- Stream 16 random transactions back-to-back with out_ready=1 -> in_ready is 1 throughout, one output per cycle in order, each output XOR equals x&y.
- Hold out_ready=0 for 5 cycles while output and stage 1 are both valid -> in_ready=0, z_sh stable; after release, two outputs appear on consecutive cycles with correct values.
- Pulse rst_n low mid-stream between edges -> out_valid and z_sh go to 0 immediately; after release, no stale output appears and the next accept gives a correct result at latency 2.
- SHARES=3, WIDTH=4, random shares and 3 random words over 100 transactions -> XOR of z shares equals x&y every time. Changing only r leaves the result unchanged while individual shares change.
